md5_apb_driver: RTL and testbench

- APB requester that feeds the codebase's MD5 APB slave core.
- Accepts a single-block message (0..55 bytes) as a byte stream and builds the 512-bit padded block.
- Writes the 16 message words over APB, holds the access phase until the core signals completion, then reads back the four digest words and presents the 128-bit digest.
- Sits between a host byte source and the md5 core; drives the core's P* inputs.

---
 rtl/md5_apb_pkg.sv | 25 ++
 rtl/md5_pad_buffer.sv | 55 +++++
 rtl/md5_apb_driver.sv | 181 ++++++++++++++++++
 tb/tb_md5_apb_driver.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_apb_pkg.sv
// Shared types and constants for the MD5 APB requester and its padding buffer.
// The byte-swap helper matches the core's little-endian length convention.
package md5_apb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        COLLECT,
        WR_SETUP,
        WR_ACCESS,
        HASH_SETUP,
        HASH_WAIT,
        RD_SETUP,
        RD_ACCESS,
        DONE
    } state_t;

    localparam logic [4:0] MSG_BASE    = 5'h00;
    localparam logic [4:0] DIGEST_BASE = 5'h10;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    function automatic logic [31:0] byte_swap(input logic [31:0] word);
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
    endfunction

endpackage

// File: rtl/md5_pad_buffer.sv
// 64-byte message store with a combinational padded-word view.
// Bytes past the message length are synthesised, so stale contents never leak into a block.
module md5_pad_buffer
    import md5_apb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [5:0]  len,
    input  logic [3:0]  word_idx,
    output logic [31:0] word_out
);

    logic [7:0] mem [64];
    logic [8:0] bit_len;
    logic [5:0] byte_addr;
    logic [7:0] pad_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) mem[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < 64; k++) mem[k] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign bit_len = {len, 3'b000};

    // Word 14 carries the bit length; len <= 55 keeps bytes 56..63 out of the message area.
    always_comb begin
        word_out  = '0;
        byte_addr = '0;
        pad_byte  = '0;
        for (int j = 0; j < 4; j++) begin
            byte_addr = {word_idx, 2'(j)};
            if (byte_addr < len)
                pad_byte = mem[byte_addr];
            else if (byte_addr == len)
                pad_byte = PAD_BYTE;
            else
                pad_byte = '0;
            word_out[31 - 8*j -: 8] = pad_byte;
        end
        if (word_idx == 4'd14)
            word_out = byte_swap({23'd0, bit_len});
        else if (word_idx == 4'd15)
            word_out = '0;
    end

endmodule

// File: rtl/md5_apb_driver.sv
// APB requester for the MD5 core: collects a single-block message, writes the
// padded words, holds the hash access until ready, then reads back the digest.
module md5_apb_driver
    import md5_apb_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int MAX_LEN = 55
) (
    input  logic         PCLK_IN,
    input  logic         PRESETn_IN,
    input  logic         start_in,
    input  logic [5:0]   len_in,
    input  logic         byte_valid_in,
    input  logic [7:0]   byte_in,
    output logic         byte_ready_out,
    output logic         PSEL_OUT,
    output logic         PENABLE_OUT,
    output logic         PWRITE_OUT,
    output logic [4:0]   PADDR_OUT,
    output logic [31:0]  PWDATA_OUT,
    input  logic [31:0]  PRDATA_IN,
    input  logic         PREADY_IN,
    output logic         busy_out,
    output logic         done_out,
    output logic         err_out,
    output logic [127:0] digest_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_next;
    logic [5:0]        len_q;
    logic [5:0]        byte_cnt;
    logic [3:0]        word_idx;
    logic [1:0]        rd_idx;
    logic [CNT_W-1:0]  timeout_cnt;
    logic              err_q;
    logic [31:0]       last_wdata;
    logic [0:3][31:0]  digest_q;
    logic [31:0]       word_data;

    logic start_ok;
    logic start_bad;
    logic byte_fire;
    logic hash_timeout;
    logic rd_fire;

    assign start_ok     = (state == IDLE) && start_in && (len_in <= 6'(MAX_LEN));
    assign start_bad    = (state == IDLE) && start_in && (len_in > 6'(MAX_LEN));
    assign byte_fire    = (state == COLLECT) && byte_valid_in;
    assign hash_timeout = (state == HASH_WAIT) && !PREADY_IN
                          && (timeout_cnt == CNT_W'(TIMEOUT - 1));
    assign rd_fire      = (state == RD_ACCESS) && PREADY_IN;

    md5_pad_buffer u_pad_buffer (
        .clk      (PCLK_IN),
        .rst_n    (PRESETn_IN),
        .clear    (start_ok),
        .wr_en    (byte_fire),
        .wr_addr  (byte_cnt),
        .wr_data  (byte_in),
        .len      (len_q),
        .word_idx (word_idx),
        .word_out (word_data)
    );

    always_ff @(posedge PCLK_IN or negedge PRESETn_IN) begin
        if (!PRESETn_IN) state <= IDLE;
        else             state <= state_next;
    end

    // Word and read indices wrap to zero after their last beat, ready for the next job.
    always_ff @(posedge PCLK_IN or negedge PRESETn_IN) begin
        if (!PRESETn_IN) begin
            len_q       <= '0;
            byte_cnt    <= '0;
            word_idx    <= '0;
            rd_idx      <= '0;
            timeout_cnt <= '0;
            err_q       <= 1'b0;
            last_wdata  <= '0;
            digest_q    <= '0;
        end else begin
            err_q <= start_bad || hash_timeout;
            if (start_ok) begin
                len_q    <= len_in;
                byte_cnt <= '0;
                word_idx <= '0;
                rd_idx   <= '0;
            end
            if (byte_fire)
                byte_cnt <= byte_cnt + 6'd1;
            if (state == WR_ACCESS) begin
                last_wdata <= word_data;
                word_idx   <= word_idx + 4'd1;
            end
            if (state == HASH_SETUP)
                timeout_cnt <= '0;
            else if (state == HASH_WAIT)
                timeout_cnt <= timeout_cnt + 1'b1;
            if (rd_fire) begin
                digest_q[rd_idx] <= PRDATA_IN;
                rd_idx           <= rd_idx + 2'd1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        PSEL_OUT       = 1'b0;
        PENABLE_OUT    = 1'b0;
        PWRITE_OUT     = 1'b0;
        PADDR_OUT      = MSG_BASE;
        PWDATA_OUT     = last_wdata;
        byte_ready_out = 1'b0;
        done_out       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok)
                    state_next = (len_in == 6'd0) ? WR_SETUP : COLLECT;
            end
            COLLECT: begin
                byte_ready_out = 1'b1;
                if (byte_fire && (byte_cnt == len_q - 6'd1))
                    state_next = WR_SETUP;
            end
            WR_SETUP: begin
                PSEL_OUT   = 1'b1;
                PWRITE_OUT = 1'b1;
                PADDR_OUT  = MSG_BASE + {1'b0, word_idx};
                PWDATA_OUT = word_data;
                state_next = WR_ACCESS;
            end
            WR_ACCESS: begin
                PSEL_OUT    = 1'b1;
                PENABLE_OUT = 1'b1;
                PWRITE_OUT  = 1'b1;
                PADDR_OUT   = MSG_BASE + {1'b0, word_idx};
                PWDATA_OUT  = word_data;
                state_next  = (word_idx == 4'd15) ? HASH_SETUP : WR_SETUP;
            end
            HASH_SETUP: begin
                PSEL_OUT   = 1'b1;
                PADDR_OUT  = DIGEST_BASE;
                state_next = HASH_WAIT;
            end
            HASH_WAIT: begin
                PSEL_OUT    = 1'b1;
                PENABLE_OUT = 1'b1;
                PADDR_OUT   = DIGEST_BASE;
                if (PREADY_IN)
                    state_next = RD_SETUP;
                else if (hash_timeout)
                    state_next = IDLE;
            end
            RD_SETUP: begin
                PSEL_OUT   = 1'b1;
                PADDR_OUT  = DIGEST_BASE + {3'b000, rd_idx};
                state_next = RD_ACCESS;
            end
            RD_ACCESS: begin
                PSEL_OUT    = 1'b1;
                PENABLE_OUT = 1'b1;
                PADDR_OUT   = DIGEST_BASE + {3'b000, rd_idx};
                if (rd_fire)
                    state_next = (rd_idx == 2'd3) ? DONE : RD_SETUP;
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_out   = (state != IDLE) && (state != DONE);
    assign err_out    = err_q;
    assign digest_out = digest_q;

endmodule

// File: tb/tb_md5_apb_driver.sv
// Directed bench for md5_apb_driver with a small APB slave model and negedge monitor.
module tb_md5_apb_driver;

    localparam int TIMEOUT = 256;

    logic         PCLK_IN = 1'b0;
    logic         PRESETn_IN;
    logic         start_in;
    logic [5:0]   len_in;
    logic         byte_valid_in;
    logic [7:0]   byte_in;
    logic         byte_ready_out;
    logic         PSEL_OUT;
    logic         PENABLE_OUT;
    logic         PWRITE_OUT;
    logic [4:0]   PADDR_OUT;
    logic [31:0]  PWDATA_OUT;
    logic [31:0]  PRDATA_IN;
    logic         PREADY_IN;
    logic         busy_out;
    logic         done_out;
    logic         err_out;
    logic [127:0] digest_out;

    always #5 PCLK_IN = ~PCLK_IN;

    md5_apb_driver #(.TIMEOUT(TIMEOUT), .MAX_LEN(55)) dut (
        .PCLK_IN        (PCLK_IN),
        .PRESETn_IN     (PRESETn_IN),
        .start_in       (start_in),
        .len_in         (len_in),
        .byte_valid_in  (byte_valid_in),
        .byte_in        (byte_in),
        .byte_ready_out (byte_ready_out),
        .PSEL_OUT       (PSEL_OUT),
        .PENABLE_OUT    (PENABLE_OUT),
        .PWRITE_OUT     (PWRITE_OUT),
        .PADDR_OUT      (PADDR_OUT),
        .PWDATA_OUT     (PWDATA_OUT),
        .PRDATA_IN      (PRDATA_IN),
        .PREADY_IN      (PREADY_IN),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .err_out        (err_out),
        .digest_out     (digest_out)
    );

    logic        ready_en;
    logic [31:0] rd_words [4];
    assign PREADY_IN = ready_en;
    assign PRDATA_IN = (PADDR_OUT >= 5'h10) ? rd_words[PADDR_OUT[1:0]] : 32'hDEAD_BEEF;

    logic [31:0] wr_mem [16];
    logic [4:0]  wr_log [1024];
    int wr_cnt = 0, setup_cnt = 0, psel_cnt = 0, done_cnt = 0, err_cnt = 0;
    int ready_cycles = 0, hash_cycles = 0, double_access = 0;
    logic prev_wr_access = 1'b0;

    always @(negedge PCLK_IN) begin
        if (PSEL_OUT && PWRITE_OUT && PENABLE_OUT) begin
            wr_mem[PADDR_OUT[3:0]] = PWDATA_OUT;
            wr_log[wr_cnt % 1024]  = PADDR_OUT;
            wr_cnt++;
            if (prev_wr_access) double_access++;
        end
        prev_wr_access = PSEL_OUT && PWRITE_OUT && PENABLE_OUT;
        if (PSEL_OUT && PWRITE_OUT && !PENABLE_OUT) setup_cnt++;
        if (PSEL_OUT) psel_cnt++;
        if (done_out) done_cnt++;
        if (err_out) err_cnt++;
        if (byte_ready_out) ready_cycles++;
        if (PSEL_OUT && PENABLE_OUT && !PWRITE_OUT && PADDR_OUT == 5'h10) hash_cycles++;
    end

    int errors = 0;
    int checks = 0;

    logic [7:0]   msg [64];
    int           job_done, job_err, job_cycles;
    logic [127:0] job_digest;

    task automatic run_job(input logic [5:0] len);
        int sent = 0;
        int budget = 0;
        job_done = 0;
        job_err = 0;
        job_digest = '0;
        @(negedge PCLK_IN);
        start_in = 1'b1;
        len_in = len;
        @(negedge PCLK_IN);
        start_in = 1'b0;
        while (sent < int'(len) && budget < 1000) begin
            byte_valid_in = 1'b1;
            byte_in = msg[sent];
            if (byte_ready_out) sent++;
            @(negedge PCLK_IN);
            budget++;
        end
        byte_valid_in = 1'b0;
        checks++;
        if (sent != int'(len)) begin
            errors++;
            $display("[TB] FAIL byte_stream: sent %0d required %0d", sent, len);
        end
        job_cycles = 1;
        while (!done_out && !err_out && job_cycles < 2000) begin
            @(negedge PCLK_IN);
            job_cycles++;
        end
        if (done_out) begin
            job_done = 1;
            job_digest = digest_out;
        end
        if (err_out) job_err = 1;
    endtask

    task automatic test_reset;
        PRESETn_IN = 1'b0;
        start_in = 1'b0;
        len_in = '0;
        byte_valid_in = 1'b0;
        byte_in = '0;
        ready_en = 1'b1;
        #12;
        checks++;
        if ({PSEL_OUT, PENABLE_OUT, PWRITE_OUT, busy_out, done_out, err_out, byte_ready_out} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b required 0", {PSEL_OUT, PENABLE_OUT, PWRITE_OUT, busy_out, done_out, err_out, byte_ready_out});
        end
        checks++;
        if (digest_out !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_digest: got %h required 0", digest_out);
        end
        checks++;
        if ({PADDR_OUT, PWDATA_OUT} !== 37'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got addr %h data %h required 0", PADDR_OUT, PWDATA_OUT);
        end
        @(negedge PCLK_IN);
        PRESETn_IN = 1'b1;
    endtask

    task automatic test_empty;
        int base_wr = wr_cnt;
        int base_done = done_cnt;
        int bad = 0;
        rd_words[0] = 32'hd41d8cd9; rd_words[1] = 32'h8f00b204;
        rd_words[2] = 32'he9800998; rd_words[3] = 32'hecf8427e;
        ready_en = 1'b1;
        run_job(6'd0);
        checks++;
        if (job_done != 1) begin errors++; $display("[TB] FAIL empty_done: got %0d required 1", job_done); end
        checks++;
        if (job_digest !== 128'hd41d8cd98f00b204e9800998ecf8427e) begin
            errors++; $display("[TB] FAIL empty_digest: got %h required d41d8cd98f00b204e9800998ecf8427e", job_digest);
        end
        checks++;
        if (wr_mem[0] !== 32'h80000000) begin errors++; $display("[TB] FAIL empty_word0: got %h required 80000000", wr_mem[0]); end
        for (int i = 1; i < 16; i++) if (wr_mem[i] !== 32'h0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL empty_zero_words: got %0d nonzero required 0", bad); end
        checks++;
        if (wr_cnt - base_wr != 16) begin errors++; $display("[TB] FAIL empty_writes: got %0d required 16", wr_cnt - base_wr); end
        checks++;
        if (job_cycles != 43) begin errors++; $display("[TB] FAIL empty_latency: got %0d required 43", job_cycles); end
        @(negedge PCLK_IN);
        checks++;
        if (done_cnt - base_done != 1 || busy_out !== 1'b0) begin
            errors++; $display("[TB] FAIL empty_done_pulse: got %0d pulses busy %b required 1 and 0", done_cnt - base_done, busy_out);
        end
    endtask

    task automatic test_abc;
        int base_setup = setup_cnt;
        int base_wr = wr_cnt;
        int base_dbl = double_access;
        int bad = 0;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        rd_words[0] = 32'h11111111; rd_words[1] = 32'h22222222;
        rd_words[2] = 32'h33333333; rd_words[3] = 32'h44444444;
        run_job(6'd3);
        checks++;
        if (wr_mem[0] !== 32'h61626380) begin errors++; $display("[TB] FAIL abc_word0: got %h required 61626380", wr_mem[0]); end
        checks++;
        if (wr_mem[14] !== 32'h18000000) begin errors++; $display("[TB] FAIL abc_word14: got %h required 18000000", wr_mem[14]); end
        checks++;
        if (wr_mem[15] !== 32'h0) begin errors++; $display("[TB] FAIL abc_word15: got %h required 0", wr_mem[15]); end
        for (int i = 1; i < 14; i++) if (wr_mem[i] !== 32'h0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL abc_zero_words: got %0d nonzero required 0", bad); end
        checks++;
        if (setup_cnt - base_setup != 16 || wr_cnt - base_wr != 16) begin
            errors++; $display("[TB] FAIL abc_pairs: got %0d setups %0d accesses required 16", setup_cnt - base_setup, wr_cnt - base_wr);
        end
        checks++;
        if (double_access != base_dbl) begin errors++; $display("[TB] FAIL abc_penable_width: got %0d long accesses required 0", double_access - base_dbl); end
        checks++;
        if (job_digest !== 128'h11111111222222223333333344444444) begin
            errors++; $display("[TB] FAIL abc_digest: got %h required 11111111222222223333333344444444", job_digest);
        end
        checks++;
        if (job_cycles != 43) begin errors++; $display("[TB] FAIL abc_latency: got %0d required 43", job_cycles); end
    endtask

    task automatic test_max_len;
        int base_ready = ready_cycles;
        for (int k = 0; k < 55; k++) msg[k] = 8'(k + 1);
        run_job(6'd55);
        checks++;
        if (ready_cycles - base_ready != 55) begin errors++; $display("[TB] FAIL max_ready: got %0d required 55", ready_cycles - base_ready); end
        checks++;
        if (wr_mem[0] !== 32'h01020304) begin errors++; $display("[TB] FAIL max_word0: got %h required 01020304", wr_mem[0]); end
        checks++;
        if (wr_mem[12] !== 32'h31323334) begin errors++; $display("[TB] FAIL max_word12: got %h required 31323334", wr_mem[12]); end
        checks++;
        if (wr_mem[13] !== 32'h35363780) begin errors++; $display("[TB] FAIL max_word13: got %h required 35363780", wr_mem[13]); end
        checks++;
        if (wr_mem[14] !== 32'hB8010000) begin errors++; $display("[TB] FAIL max_word14: got %h required b8010000", wr_mem[14]); end
        checks++;
        if (job_done != 1) begin errors++; $display("[TB] FAIL max_done: got %0d required 1", job_done); end
    endtask

    task automatic test_bad_len;
        int base_psel = psel_cnt;
        int base_err = err_cnt;
        @(negedge PCLK_IN);
        start_in = 1'b1;
        len_in = 6'd56;
        @(negedge PCLK_IN);
        start_in = 1'b0;
        checks++;
        if (err_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++; $display("[TB] FAIL bad_len_err: got err %b busy %b required 1 and 0", err_out, busy_out);
        end
        @(negedge PCLK_IN);
        start_in = 1'b1;
        len_in = 6'd63;
        @(negedge PCLK_IN);
        start_in = 1'b0;
        repeat (6) @(negedge PCLK_IN);
        checks++;
        if (err_cnt - base_err != 2) begin errors++; $display("[TB] FAIL bad_len_pulses: got %0d required 2", err_cnt - base_err); end
        checks++;
        if (psel_cnt != base_psel) begin errors++; $display("[TB] FAIL bad_len_psel: got %0d cycles required 0", psel_cnt - base_psel); end
    endtask

    task automatic test_timeout;
        int base_hash = hash_cycles;
        int base_done = done_cnt;
        ready_en = 1'b0;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_job(6'd3);
        checks++;
        if (job_err != 1 || job_done != 0) begin
            errors++; $display("[TB] FAIL timeout_err: got err %0d done %0d required 1 and 0", job_err, job_done);
        end
        checks++;
        if (job_cycles != 32 + 1 + TIMEOUT + 1) begin
            errors++; $display("[TB] FAIL timeout_latency: got %0d required %0d", job_cycles, 32 + 1 + TIMEOUT + 1);
        end
        checks++;
        if (hash_cycles - base_hash != TIMEOUT) begin
            errors++; $display("[TB] FAIL timeout_wait: got %0d required %0d", hash_cycles - base_hash, TIMEOUT);
        end
        checks++;
        if ({busy_out, PSEL_OUT, PENABLE_OUT} !== 3'b0 || done_cnt != base_done) begin
            errors++; $display("[TB] FAIL timeout_idle: got busy/psel/penable %b done %0d required 000 and 0", {busy_out, PSEL_OUT, PENABLE_OUT}, done_cnt - base_done);
        end
        ready_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int budget = 0;
        int base_wr;
        @(negedge PCLK_IN);
        start_in = 1'b1;
        len_in = 6'd0;
        @(negedge PCLK_IN);
        start_in = 1'b0;
        while (!(PSEL_OUT && PWRITE_OUT && PADDR_OUT == 5'd7) && budget < 100) begin
            @(negedge PCLK_IN);
            budget++;
        end
        checks++;
        if (budget >= 100) begin errors++; $display("[TB] FAIL mid_reach_word7: got timeout required word 7"); end
        #1 PRESETn_IN = 1'b0;
        #1;
        checks++;
        if ({PSEL_OUT, PENABLE_OUT, busy_out} !== 3'b0) begin
            errors++; $display("[TB] FAIL mid_reset_drop: got psel/penable/busy %b required 000", {PSEL_OUT, PENABLE_OUT, busy_out});
        end
        @(negedge PCLK_IN);
        PRESETn_IN = 1'b1;
        base_wr = wr_cnt;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_job(6'd3);
        checks++;
        if (wr_log[base_wr % 1024] !== 5'd0 || wr_cnt - base_wr != 16) begin
            errors++; $display("[TB] FAIL mid_restart: got first addr %h writes %0d required 0 and 16", wr_log[base_wr % 1024], wr_cnt - base_wr);
        end
        checks++;
        if (wr_mem[0] !== 32'h61626380 || job_digest !== 128'h11111111222222223333333344444444) begin
            errors++; $display("[TB] FAIL mid_result: got word0 %h digest %h required 61626380 and 1111..4444", wr_mem[0], job_digest);
        end
    endtask

    initial begin
        test_reset;
        test_empty;
        test_abc;
        test_max_len;
        test_bad_len;
        test_timeout;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
